// File: rtl/ramp_conversion_counter.sv
// Single-slope conversion controller: ramps a code to the DAC after a start request and
// captures the code on the first comparator crossing, flagging overflow at full scale.
module ramp_conversion_counter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_COUNT = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_edge,
    output logic             sampler_rst,
    output logic             busy,
    output logic [WIDTH-1:0] ramp_code,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MaxCode = WIDTH'(MAX_COUNT);

    typedef enum logic [1:0] {StIdle, StClear, StCount} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ramp_q, ramp_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             srst_q, srst_d;

    always_comb begin
        state_d  = state_q;
        ramp_d   = ramp_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                ramp_d = '0;
                if (start) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                ramp_d  = '0;
                state_d = StCount;
            end
            StCount: begin
                // A crossing on the terminal code still counts as a crossing.
                if (cmp_edge || (ramp_q == MaxCode)) begin
                    result_d = ramp_q;
                    ovf_d    = ~cmp_edge;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                    ramp_d   = '0;
                end else begin
                    ramp_d = ramp_q + WIDTH'(1);
                end
            end
            default: begin
                state_d = StIdle;
                ramp_d  = '0;
            end
        endcase
        // Outputs are registered, so derive them from the state being entered.
        busy_d = (state_d != StIdle);
        srst_d = (state_d != StCount);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ramp_q   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            srst_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            ramp_q   <= ramp_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            srst_q   <= srst_d;
        end
    end

    assign sampler_rst = srst_q;
    assign busy        = busy_q;
    assign ramp_code   = ramp_q;
    assign done        = done_q;
    assign result      = result_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_ramp_conversion_counter.sv
// Randomized bench for ramp_conversion_counter; a timeline model predicts each conversion's
// outputs from the cycle its start was accepted and the planned crossing code.
module tb_ramp_conversion_counter;

    localparam int W    = 8;
    localparam int MAXC = 255;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         cmp_edge;
    logic         sampler_rst;
    logic         busy;
    logic [W-1:0] ramp_code;
    logic         done;
    logic [W-1:0] result;
    logic         overflow;

    always #5 clk = ~clk;

    ramp_conversion_counter #(
        .WIDTH     (W),
        .MAX_COUNT (MAXC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cmp_edge    (cmp_edge),
        .sampler_rst (sampler_rst),
        .busy        (busy),
        .ramp_code   (ramp_code),
        .done        (done),
        .result      (result),
        .overflow    (overflow)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: a conversion accepted at posedge acc is in CLEAR until acc+1, then shows
    // ramp code (cyc-acc-1), and completes at done_at. edge_k < 0 means no crossing.
    bit act;
    int acc;
    int done_at;
    int edge_k;
    int res_m;
    bit ovf_m;
    bit done_m;
    bit did_rst100;
    int convs;
    int directed[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int pick_edge();
        int r;
        r = int'($urandom_range(3, 0));
        if (r == 0) return -1;
        if (r == 1) return MAXC - int'($urandom_range(3, 0));
        return int'($urandom_range(MAXC, 0));
    endfunction

    initial begin
        int exp_ramp;
        bit idle_pre;
        rst_n      = 1'b0;
        start      = 1'b0;
        cmp_edge   = 1'b0;
        act        = 1'b0;
        acc        = 0;
        done_at    = 0;
        edge_k     = -1;
        res_m      = 0;
        ovf_m      = 1'b0;
        done_m     = 1'b0;
        did_rst100 = 1'b0;
        convs      = 0;
        directed   = '{37, -1, 255, 0, -1};

        while (convs < 45 && cyc < 40000) begin
            // Inputs for the coming posedge.
            idle_pre = !act;
            if (cyc < 3) begin
                rst_n = 1'b0;
            end else if (!did_rst100 && directed.size() == 0 && act && cyc > acc
                         && (cyc - acc - 1) == 100) begin
                rst_n      = 1'b0;
                did_rst100 = 1'b1;
            end else begin
                rst_n = ($urandom_range(499, 0) != 0);
            end

            if (cyc < 8) start = 1'b0;
            else if (!act) start = ($urandom_range(1, 0) == 1);
            else start = ($urandom_range(9, 0) == 0);

            if (act && cyc > acc && edge_k >= 0 && (cyc - acc - 1) == edge_k) cmp_edge = 1'b1;
            else if (!act || cyc == acc) cmp_edge = ($urandom_range(3, 0) == 0);
            else cmp_edge = 1'b0;

            @(posedge clk);
            cyc++;
            done_m = 1'b0;
            if (!rst_n) begin
                act   = 1'b0;
                res_m = 0;
                ovf_m = 1'b0;
            end else if (act && cyc == done_at) begin
                done_m = 1'b1;
                act    = 1'b0;
                convs++;
                if (edge_k >= 0) begin
                    res_m = edge_k;
                    ovf_m = 1'b0;
                end else begin
                    res_m = MAXC;
                    ovf_m = 1'b1;
                end
            end else if (idle_pre && start) begin
                act     = 1'b1;
                acc     = cyc;
                edge_k  = (directed.size() != 0) ? directed.pop_front() : pick_edge();
                done_at = acc + 2 + ((edge_k >= 0) ? edge_k : MAXC);
            end

            #1;
            exp_ramp = (act && cyc > acc) ? (cyc - acc - 1) : 0;
            check_eq("ramp_code", 32'(ramp_code), 32'(exp_ramp));
            check_eq("busy", 32'(busy), 32'(act));
            check_eq("sampler_rst", 32'(sampler_rst), 32'(!act || cyc == acc));
            check_eq("done", 32'(done), 32'(done_m));
            check_eq("result", 32'(result), 32'(res_m));
            check_eq("overflow", 32'(overflow), 32'(ovf_m));
        end

        check_eq("conversions_completed", 32'(convs >= 45), 32'(1));
        check_eq("reset_at_100_exercised", 32'(did_rst100), 32'(1));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ramp_conversion_counter.md
Name: ramp_conversion_counter

Overview:
- Single-slope conversion controller. Sits directly downstream of the comparator edge sampler and consumes its one-cycle comparator-crossing pulse.
- On `start`, it re-arms the sampler, runs a ramp code counter and drives that code to the ramp DAC.
- On the first comparator edge it captures the ramp code as the conversion result.
- Runs without a crossing terminate at full scale and set an overflow flag.

Parameters:
- WIDTH, 8, width of ramp code and result.
- MAX_COUNT, 2**WIDTH-1, terminal ramp code; a conversion with no edge ends here. Legal range 1..2**WIDTH-1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request a conversion; honoured only in IDLE.
- cmp_edge  input  1  one-cycle comparator-crossing pulse from the edge sampler; honoured only in COUNT.
- sampler_rst  output  1  active-high reset to the edge sampler; deasserted only while counting.
- busy  output  1  high in CLEAR and COUNT.
- ramp_code  output  WIDTH  current ramp code to the DAC.
- done  output  1  one-cycle pulse; result/overflow updated in the same cycle.
- result  output  WIDTH  captured code of the last conversion; held until the next done.
- overflow  output  1  last conversion hit MAX_COUNT with no edge; held until the next done.

Behaviour:
- Reset (rst_n=0 at posedge):
  - State returns to IDLE.
  - ramp_code=0, result=0, overflow=0, done=0, busy=0, sampler_rst=1.
  - Reset mid-conversion aborts it with no done pulse.
- All outputs are registered.
- States: IDLE, CLEAR, COUNT.
- IDLE:
  - sampler_rst=1, ramp_code=0.
  - start=1 -> CLEAR.
  - cmp_edge is ignored.
- CLEAR:
  - Lasts exactly one cycle; sampler_rst=1 (flushes sticky hold in the sampler).
  - Then -> COUNT with ramp_code=0.
- COUNT:
  - sampler_rst=0, busy=1.
  - ramp_code increments by 1 each cycle.
  - If cmp_edge=1 in a cycle where ramp_code=k, then at the next posedge:
    - result<=k, overflow<=0, done<=1.
    - state -> IDLE, ramp_code<=0, sampler_rst<=1.
  - Else if ramp_code==MAX_COUNT, then at the next posedge:
    - result<=MAX_COUNT, overflow<=1, done<=1.
    - state -> IDLE.
  - cmp_edge and ramp_code==MAX_COUNT in the same cycle: the edge wins; result=MAX_COUNT, overflow=0.
  - ramp_code never wraps.
- Latency:
  - start sampled at posedge T -> CLEAR from T.
  - COUNT with ramp_code=0 from T+1.
  - First possible done at T+2; no-edge done at T+2+MAX_COUNT.
- start while busy is ignored; it is not queued.
- start=1 in the same cycle done is asserted: accepted (state is IDLE that cycle), giving back-to-back conversions.
- done is high for exactly one cycle per completed conversion.
- result and overflow change only on done or reset.
- Any pipeline delay of the sampler is absorbed by the consumer; this block records ramp_code at the cycle cmp_edge is seen.

Test Plan:
- Reset release, idle 5 cycles -> ramp_code=0, result=0, overflow=0, done=0, busy=0, sampler_rst=1 throughout.
- Conversion with edge: start pulse, cmp_edge pulsed when ramp_code=37 -> done one cycle later, result=37, overflow=0, busy falls with done, sampler_rst high again.
- Full-scale, no crossing (WIDTH=8): start, cmp_edge never asserted -> done at 2+255 cycles after start, result=255, overflow=1, ramp_code never exceeds 255.
- Edge exactly at terminal code: cmp_edge when ramp_code=255 -> result=255, overflow=0. Edge at ramp_code=0 (first COUNT cycle) -> result=0.
- Ignored inputs:
  - cmp_edge in IDLE and CLEAR -> no done.
  - start during COUNT -> no restart; ramp_code keeps incrementing.
  - start coincident with done -> new CLEAR next cycle, second conversion result independent of the first.
- rst_n=0 while ramp_code=100 -> next cycle IDLE, ramp_code=0, no done; result/overflow reset to 0.
